missile_l_motion_ctrl: RTL

Sequencer directly upstream of the left-missile sprite control block. It drives that block's draw/clear/shift_hv/load strobes and shift amounts in 64-pixel bursts, and generates the VGA plot enable. It loads a launch position, then runs a per-frame erase/move/redraw loop until the missile leaves the playfield or is aborted. It tracks the current position itself and checks burst alignment against the sprite block's complete flag.

---
 rtl/missile_l_motion_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/missile_l_motion_ctrl.sv
// Left-missile motion sequencer: launches a sprite, then runs a per-frame
// erase/move/redraw loop in 64-cycle bursts until it leaves the playfield or is aborted.
module missile_l_motion_ctrl #(
    parameter int unsigned FRAME_TICKS = 833333,
    parameter int unsigned STEP_X      = 1,
    parameter int unsigned STEP_Y      = 0,
    parameter int unsigned X_MIN       = 0,
    parameter int unsigned Y_MAX       = 116
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       launch,
    input  logic [7:0] launch_x,
    input  logic [6:0] launch_y,
    input  logic       abort,
    input  logic       complete,
    output logic       draw,
    output logic       clear,
    output logic       shift_hv,
    output logic       shift_v,
    output logic       load,
    output logic [7:0] load_x,
    output logic [6:0] load_y,
    output logic [6:0] shift_amount,
    output logic [6:0] shift_amount_two,
    output logic       plot,
    output logic       busy,
    output logic       exited,
    output logic [7:0] cur_x,
    output logic [6:0] cur_y,
    output logic       error
);

    localparam int unsigned FW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS + 1) : 1;

    typedef enum logic [2:0] {
        S_RESYNC,
        S_IDLE,
        S_LOAD,
        S_DRAW0,
        S_WAIT,
        S_ERASE,
        S_MOVE,
        S_FINAL
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [5:0]      burst_cnt;
    logic [FW-1:0]   frame_cnt;
    logic            in_burst;
    logic            burst_end;
    logic            frame_end;
    logic            out_of_bounds;
    logic signed [9:0] next_x_s;
    logic [7:0]      next_y;

    logic draw_d, clear_d, shift_hv_d, load_d, plot_d, busy_d, exited_d;
    logic [6:0] shift_amount_d, shift_amount_two_d;

    assign in_burst  = (state == S_DRAW0) || (state == S_ERASE) ||
                       (state == S_MOVE)  || (state == S_FINAL);
    assign burst_end = in_burst && (burst_cnt == 6'd63);
    assign frame_end = (state == S_WAIT) && (frame_cnt == FW'(FRAME_TICKS - 1));

    // Signed x keeps the borrow visible as a negative value.
    assign next_x_s      = $signed({2'b00, cur_x}) - $signed(10'(STEP_X));
    assign next_y        = {1'b0, cur_y} + 8'(STEP_Y);
    assign out_of_bounds = (next_x_s < $signed(10'(X_MIN))) || (next_y > 8'(Y_MAX));

    assign shift_v = 1'b0;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_RESYNC;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_RESYNC: if (complete) state_nx = S_IDLE;
            S_IDLE:   if (launch)   state_nx = S_LOAD;
            S_LOAD:   state_nx = S_DRAW0;
            S_DRAW0:  if (burst_end) state_nx = S_WAIT;
            S_WAIT: begin
                if (frame_end) begin
                    if (abort || out_of_bounds) state_nx = S_FINAL;
                    else                        state_nx = S_ERASE;
                end
            end
            S_ERASE:  if (burst_end) state_nx = S_MOVE;
            S_MOVE:   if (burst_end) state_nx = S_WAIT;
            S_FINAL:  if (burst_end) state_nx = S_IDLE;
            default:  state_nx = S_RESYNC;
        endcase
    end

    // Output decode from the upcoming state so registered strobes line up with it
    always_comb begin
        draw_d             = 1'b0;
        clear_d            = 1'b0;
        shift_hv_d         = 1'b0;
        load_d             = 1'b0;
        plot_d             = 1'b0;
        busy_d             = 1'b0;
        shift_amount_d     = 7'd0;
        shift_amount_two_d = 7'd0;
        exited_d           = (state == S_FINAL) && burst_end;
        case (state_nx)
            S_RESYNC: begin
                draw_d  = 1'b1;
                clear_d = 1'b1;
            end
            S_LOAD: begin
                draw_d = 1'b1;
                load_d = 1'b1;
                busy_d = 1'b1;
            end
            S_DRAW0: begin
                draw_d     = 1'b1;
                plot_d     = 1'b1;
                shift_hv_d = 1'b1;
                busy_d     = 1'b1;
            end
            S_WAIT: busy_d = 1'b1;
            S_ERASE, S_FINAL: begin
                draw_d  = 1'b1;
                plot_d  = 1'b1;
                clear_d = 1'b1;
                busy_d  = 1'b1;
            end
            S_MOVE: begin
                draw_d             = 1'b1;
                plot_d             = 1'b1;
                shift_hv_d         = 1'b1;
                busy_d             = 1'b1;
                shift_amount_d     = 7'(STEP_X);
                shift_amount_two_d = 7'(STEP_Y);
            end
            default: ;
        endcase
    end

    // Counters, position tracking, alignment flag and output registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            burst_cnt        <= 6'd0;
            frame_cnt        <= '0;
            error            <= 1'b0;
            load_x           <= 8'd0;
            load_y           <= 7'd0;
            cur_x            <= 8'd0;
            cur_y            <= 7'd0;
            draw             <= 1'b0;
            clear            <= 1'b0;
            shift_hv         <= 1'b0;
            load             <= 1'b0;
            plot             <= 1'b0;
            busy             <= 1'b0;
            exited           <= 1'b0;
            shift_amount     <= 7'd0;
            shift_amount_two <= 7'd0;
        end else begin
            burst_cnt <= in_burst ? burst_cnt + 6'd1 : 6'd0;
            frame_cnt <= ((state != S_WAIT) || frame_end) ? '0 : frame_cnt + FW'(1);
            if (burst_end && !complete) error <= 1'b1;
            if ((state == S_IDLE) && launch) begin
                load_x <= launch_x;
                load_y <= launch_y;
                cur_x  <= launch_x;
                cur_y  <= launch_y;
            end else if ((state == S_MOVE) && burst_end) begin
                cur_x <= cur_x - 8'(STEP_X);
                cur_y <= cur_y + 7'(STEP_Y);
            end
            draw             <= draw_d;
            clear            <= clear_d;
            shift_hv         <= shift_hv_d;
            load             <= load_d;
            plot             <= plot_d;
            busy             <= busy_d;
            exited           <= exited_d;
            shift_amount     <= shift_amount_d;
            shift_amount_two <= shift_amount_two_d;
        end
    end

endmodule
